// File: rtl/fmcw_usb_packetizer.sv
// Buffers decimated FMCW samples in a FIFO and streams them MSB-byte-first to an FT2232H,
// framing each chirp with FF FF <frame count>. Overflowed chirps are discarded up to the next header.
module fmcw_usb_packetizer #(
    parameter int DW      = 14,
    parameter int FIFO_AW = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      data_i,
    input  logic               valid_i,
    input  logic               frame_start_i,
    output logic [7:0]         ft_data_o,
    output logic               ft_wr_o,
    input  logic               ft_txe_n_i,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               overflow_o,
    output logic [7:0]         frame_cnt_o
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, SMSB, SLSB} state_t;

    logic [DW:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               drop_q, drop_d, overflow_q;
    logic               full, empty, push, pop, xfer;
    logic [DW:0]        head;

    state_t             state_q;
    logic [DW:0]        hold_q;
    logic [7:0]         ft_data_q, frame_cnt_q;
    logic               ft_wr_q;

    function automatic logic [7:0] msb_byte(input logic [DW-1:0] d);
        logic [15:0] w;
        w = 16'(d);
        return w[15:8];
    endfunction

    function automatic logic [7:0] lsb_byte(input logic [DW-1:0] d);
        logic [15:0] w;
        w = 16'(d);
        return w[7:0];
    endfunction

    assign full  = (level_q == (FIFO_AW + 1)'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign xfer  = ft_wr_q && !ft_txe_n_i;
    assign pop   = !empty && ((state_q == IDLE) || (state_q == SLSB && xfer));

    // A full FIFO refuses every sample; only a sop with space ends a drop run.
    always_comb begin
        push   = 1'b0;
        drop_d = drop_q;
        if (valid_i) begin
            if (full) begin
                drop_d = 1'b1;
            end else if (frame_start_i) begin
                drop_d = 1'b0;
                push   = 1'b1;
            end else if (!drop_q) begin
                push   = 1'b1;
            end
        end
    end

    assign level_d = level_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);

    // NOTE: the sample storage has no reset; pointers and level define what is valid,
    // and leaving the array unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {frame_start_i, data_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            drop_q  <= drop_d;
            if (valid_i && full) overflow_q <= 1'b1;
        end
    end

    // state_q names the byte on ft_data_o; leaving IDLE arms it for one cycle with ft_wr_o low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            ft_data_q   <= '0;
            ft_wr_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (pop) begin
                hold_q  <= head;
                state_q <= head[DW] ? HDR0 : SMSB;
            end
        end else if (!ft_wr_q) begin
            ft_wr_q   <= 1'b1;
            ft_data_q <= (state_q == SMSB) ? msb_byte(hold_q[DW-1:0]) : 8'hFF;
        end else if (xfer) begin
            case (state_q)
                HDR0: begin
                    state_q   <= HDR1;
                    ft_data_q <= 8'hFF;
                end
                HDR1: begin
                    state_q   <= HDR2;
                    ft_data_q <= frame_cnt_q;
                end
                HDR2: begin
                    state_q     <= SMSB;
                    ft_data_q   <= msb_byte(hold_q[DW-1:0]);
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
                SMSB: begin
                    state_q   <= SLSB;
                    ft_data_q <= lsb_byte(hold_q[DW-1:0]);
                end
                SLSB: begin
                    if (pop) begin
                        hold_q    <= head;
                        state_q   <= head[DW] ? HDR0 : SMSB;
                        ft_data_q <= head[DW] ? 8'hFF : msb_byte(head[DW-1:0]);
                    end else begin
                        state_q <= IDLE;
                        ft_wr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ft_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign ft_data_o    = ft_data_q;
    assign ft_wr_o      = ft_wr_q;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
